vertex_transform: RTL

Streaming 4x4-matrix × 4-vector transform stage sitting directly downstream of `mat_mul`. It latches the composed transform (e.g. the MVP matrix) whenever `mat_mul` pulses its output-valid, then transforms a stream of homogeneous vertices (x, y, z, w) under a valid/ready handshake. It uses the same Q-format fixed-point convention as `mat_mul` and the same one-column-per-cycle multiply-accumulate schedule. Results feed the clip/perspective-divide stage.

---
 rtl/vertex_transform.sv | 117 +++++++++++
 1 files changed

// File: rtl/vertex_transform.sv
// vertex_transform: streaming 4x4 matrix x 4-vector transform, one column per cycle; VERTEX_TRANSFORM_SATURATE_EN selects clamped output
module vertex_transform #(
  parameter int DATAWIDTH = 16,
  parameter int FRACBITS = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic signed [DATAWIDTH-1:0] M [4][4],
  input  logic i_mat_dv,
  input  logic signed [DATAWIDTH-1:0] i_vertex [4],
  input  logic i_vertex_dv,
  output logic o_vertex_ready,
  output logic signed [DATAWIDTH-1:0] o_vertex [4],
  output logic o_vertex_dv,
  input  logic i_ready,
  output logic o_mat_loaded
);
  localparam int AW = 2*DATAWIDTH+2;
  typedef enum logic [1:0] {IDLE, READY, PROC, OUT} state_t;
  state_t state;
  logic signed [DATAWIDTH-1:0] m_r [4][4];
  logic signed [DATAWIDTH-1:0] m_p [4][4];
  logic signed [DATAWIDTH-1:0] v_r [4];
  logic signed [DATAWIDTH-1:0] fmt [4];
  logic signed [2*DATAWIDTH-1:0] prod [4];
  logic signed [AW-1:0] acc [4];
  logic signed [AW-1:0] sum [4];
  logic signed [AW-1:0] sh [4];
  logic pend;
  logic [1:0] k;
`ifdef VERTEX_TRANSFORM_SATURATE_EN
  localparam logic signed [AW-1:0] MAX_V = AW'(2**(DATAWIDTH-1)-1);
  localparam logic signed [AW-1:0] MIN_V = ~MAX_V;
  // column-k MAC, then arithmetic shift and clamp to the output range
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      prod[r] = (2*DATAWIDTH)'(m_r[r][k]) * (2*DATAWIDTH)'(v_r[k]);
      sum[r] = acc[r] + AW'(prod[r]);
      sh[r] = sum[r] >>> FRACBITS;
      fmt[r] = sh[r] > MAX_V ? {1'b0, {(DATAWIDTH-1){1'b1}}} :
               sh[r] < MIN_V ? {1'b1, {(DATAWIDTH-1){1'b0}}} : sh[r][DATAWIDTH-1:0];
    end
  end
`else
  logic unused_bits;
  // column-k MAC, then arithmetic shift keeping the sign bit and wrapping the magnitude
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      prod[r] = (2*DATAWIDTH)'(m_r[r][k]) * (2*DATAWIDTH)'(v_r[k]);
      sum[r] = acc[r] + AW'(prod[r]);
      sh[r] = sum[r] >>> FRACBITS;
      fmt[r] = {sh[r][AW-1], sh[r][DATAWIDTH-2:0]};
    end
    unused_bits = ^{sh[0], sh[1], sh[2], sh[3]};
  end
`endif
  // handshake FSM, matrix load/pending logic and accumulator sequencing
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pend <= 1'b0;
      k <= '0;
      o_vertex_ready <= 1'b0;
      o_vertex_dv <= 1'b0;
      o_mat_loaded <= 1'b0;
      m_r <= '{default: '{default: '0}};
      m_p <= '{default: '{default: '0}};
      v_r <= '{default: '0};
      acc <= '{default: '0};
      o_vertex <= '{default: '0};
    end else begin
      case (state)
        IDLE: if (i_mat_dv) begin
          m_r <= M;
          o_mat_loaded <= 1'b1;
          o_vertex_ready <= 1'b1;
          state <= READY;
        end
        READY: if (i_vertex_dv) begin
          v_r <= i_vertex;
          acc <= '{default: '0};
          k <= '0;
          o_vertex_ready <= 1'b0;
          state <= PROC;
          if (i_mat_dv) begin
            m_p <= M;
            pend <= 1'b1;
          end
        end else if (i_mat_dv) m_r <= M;
        PROC: begin
          if (i_mat_dv) begin
            m_p <= M;
            pend <= 1'b1;
          end
          if (k == 2'd3) begin
            o_vertex <= fmt;
            o_vertex_dv <= 1'b1;
            state <= OUT;
          end else acc <= sum;
          k <= k + 2'd1;
        end
        OUT: if (i_ready) begin
          o_vertex_dv <= 1'b0;
          o_vertex_ready <= 1'b1;
          state <= READY;
          pend <= 1'b0;
          if (i_mat_dv) m_r <= M;
          else if (pend) m_r <= m_p;
        end else if (i_mat_dv) begin
          m_p <= M;
          pend <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
